// File: rtl/seg_display_scanner.sv
// Four-digit multiplexed seven-segment driver: captures a binary score once per
// scan frame, converts it to BCD with a shift-add-3 engine, and drives active-low pins.
module seg_display_scanner #(
  parameter int VALUE_WIDTH   = 14,
  parameter bit BLANK_LEADING = 1'b1
) (
  input  logic                   MasterClock,
  input  logic                   Reset,
  input  logic                   fastClock,
  input  logic [VALUE_WIDTH-1:0] Value,
  input  logic                   Blank,
  output logic [3:0]             an,
  output logic [6:0]             seg,
  output logic                   dp,
  output logic                   Busy
);

  localparam int CW    = (VALUE_WIDTH > 14) ? VALUE_WIDTH : 14;
  localparam int CNT_W = (VALUE_WIDTH > 1) ? $clog2(VALUE_WIDTH) : 1;
  localparam logic [CW-1:0]    MAX_VALUE = CW'(9999);
  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(VALUE_WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CONVERT = 2'd1,
    COMMIT  = 2'd2
  } state_t;

  state_t                 state_r;
  logic [1:0]             digit_r;
  logic [VALUE_WIDTH-1:0] bin_r;
  logic [15:0]            scratch_r;
  logic [15:0]            bcd_r;
  logic [CNT_W-1:0]       step_r;
  logic                   first_r;
  logic                   busy_r;
  logic [3:0]             an_r;
  logic [6:0]             seg_r;

  logic                   capture_s;
  logic [CW-1:0]          value_ext_s;
  logic [CW-1:0]          clamped_s;
  logic [3:0]             nibble_s;
  logic                   lead_zero_s;
  logic                   blank_s;

  // One shift-add-3 step: correct every nibble >= 5, then shift in the next binary bit.
  function automatic logic [15:0] bcd_step(input logic [15:0] s, input logic b);
    logic [15:0] t;
    t = s;
    for (int i = 0; i < 4; i++) begin
      if (t[4*i +: 4] >= 4'd5) begin
        t[4*i +: 4] = t[4*i +: 4] + 4'd3;
      end
    end
    return (t << 1) | {15'd0, b};
  endfunction

  function automatic logic [6:0] seg_decode(input logic [3:0] n);
    logic [6:0] r;
    case (n)
      4'd0:    r = 7'b1000000;
      4'd1:    r = 7'b1111001;
      4'd2:    r = 7'b0100100;
      4'd3:    r = 7'b0110000;
      4'd4:    r = 7'b0011001;
      4'd5:    r = 7'b0010010;
      4'd6:    r = 7'b0000010;
      4'd7:    r = 7'b1111000;
      4'd8:    r = 7'b0000000;
      4'd9:    r = 7'b0010000;
      default: r = 7'b1111111;
    endcase
    return r;
  endfunction

  // Capture request, clamp, and per-digit nibble / blanking selection.
  always_comb begin
    capture_s   = first_r | (fastClock & (digit_r == 2'd3));
    value_ext_s = CW'(Value);
    if (value_ext_s > MAX_VALUE) begin
      clamped_s = MAX_VALUE;
    end else begin
      clamped_s = value_ext_s;
    end
    case (digit_r)
      2'd0: begin nibble_s = bcd_r[3:0];   lead_zero_s = 1'b0;                 end
      2'd1: begin nibble_s = bcd_r[7:4];   lead_zero_s = (bcd_r[15:4]  == 12'd0); end
      2'd2: begin nibble_s = bcd_r[11:8];  lead_zero_s = (bcd_r[15:8]  == 8'd0);  end
      2'd3: begin nibble_s = bcd_r[15:12]; lead_zero_s = (bcd_r[15:12] == 4'd0);  end
      default: begin nibble_s = 4'd0; lead_zero_s = 1'b0; end
    endcase
    blank_s = Blank | (BLANK_LEADING & lead_zero_s);
  end

  // Digit index and conversion FSM; captures outside IDLE are dropped.
  always_ff @(posedge MasterClock) begin
    if (Reset) begin
      state_r   <= IDLE;
      digit_r   <= 2'd0;
      bin_r     <= '0;
      scratch_r <= 16'd0;
      bcd_r     <= 16'd0;
      step_r    <= '0;
      first_r   <= 1'b1;
      busy_r    <= 1'b0;
    end else begin
      first_r <= 1'b0;
      if (fastClock) begin
        digit_r <= digit_r + 2'd1;
      end
      case (state_r)
        IDLE: begin
          if (capture_s) begin
            bin_r     <= clamped_s[VALUE_WIDTH-1:0];
            scratch_r <= 16'd0;
            step_r    <= '0;
            busy_r    <= 1'b1;
            state_r   <= CONVERT;
          end
        end
        CONVERT: begin
          scratch_r <= bcd_step(scratch_r, bin_r[VALUE_WIDTH-1]);
          bin_r     <= bin_r << 1;
          step_r    <= step_r + CNT_W'(1);
          if (step_r == LAST_STEP) begin
            state_r <= COMMIT;
          end
        end
        COMMIT: begin
          bcd_r   <= scratch_r;
          busy_r  <= 1'b0;
          state_r <= IDLE;
        end
        default: state_r <= IDLE;
      endcase
    end
  end

  // Registered pin drive.
  always_ff @(posedge MasterClock) begin
    if (Reset) begin
      an_r  <= 4'b1111;
      seg_r <= 7'b1111111;
    end else if (blank_s) begin
      an_r  <= 4'b1111;
      seg_r <= 7'b1111111;
    end else begin
      an_r  <= ~(4'b0001 << digit_r);
      seg_r <= seg_decode(nibble_s);
    end
  end

  assign an   = an_r;
  assign seg  = seg_r;
  assign dp   = 1'b1;
  assign Busy = busy_r;

endmodule

// File: tb/tb_seg_display_scanner.sv
// Scoreboard bench for seg_display_scanner: expected pin patterns are queued when a
// tick is driven and compared one cycle later when the registered outputs update.
module tb_seg_display_scanner;

  logic        MasterClock = 1'b0;
  logic        Reset       = 1'b1;
  logic        fastClock   = 1'b0;
  logic [13:0] Value       = 14'd0;
  logic        Blank       = 1'b0;
  logic [3:0]  an;
  logic [6:0]  seg;
  logic        dp;
  logic        Busy;

  int n_checks = 0;
  int n_pass   = 0;
  int tb_digit = 0;
  int shown    = 0;
  int pending  = 0;
  bit pending_valid = 1'b0;
  logic [10:0] exp_q[$];
  logic [10:0] e;

  seg_display_scanner #(.VALUE_WIDTH(14), .BLANK_LEADING(1'b1)) dut (
    .MasterClock(MasterClock), .Reset(Reset), .fastClock(fastClock), .Value(Value),
    .Blank(Blank), .an(an), .seg(seg), .dp(dp), .Busy(Busy)
  );

  always #5 MasterClock = ~MasterClock;

  function automatic logic [6:0] seg_of(int n);
    case (n)
      0: return 7'b1000000;
      1: return 7'b1111001;
      2: return 7'b0100100;
      3: return 7'b0110000;
      4: return 7'b0011001;
      5: return 7'b0010010;
      6: return 7'b0000010;
      7: return 7'b1111000;
      8: return 7'b0000000;
      9: return 7'b0010000;
      default: return 7'b1111111;
    endcase
  endfunction

  function automatic logic [10:0] exp_out(int v, int d, bit blank);
    int c;
    int p;
    logic [3:0] a;
    c = (v > 9999) ? 9999 : v;
    p = 1;
    for (int k = 0; k < d; k++) p = p * 10;
    if (blank || (d > 0 && c < p)) return {4'b1111, 7'b1111111};
    a = 4'b1111;
    a[d] = 1'b0;
    return {a, seg_of((c / p) % 10)};
  endfunction

  task automatic tick();
    pending_valid = (tb_digit == 3);
    @(negedge MasterClock);
    fastClock = 1'b1;
    pending = int'(Value);
    @(negedge MasterClock);
    fastClock = 1'b0;
    tb_digit = (tb_digit + 1) % 4;
    exp_q.push_back(exp_out(shown, tb_digit, Blank));
  endtask

  task automatic settle();
    repeat (17) @(negedge MasterClock);
    if (pending_valid) shown = pending;
    pending_valid = 1'b0;
  endtask

  task automatic load(int v);
    Value = 14'(v);
    while (tb_digit != 3) begin
      tick();
      @(negedge MasterClock);
      void'(exp_q.pop_front());
      settle();
    end
    tick();
    @(negedge MasterClock);
    void'(exp_q.pop_front());
    settle();
  endtask

  task automatic test_reset();
    int busy_cycles;
    Reset = 1'b1;
    repeat (3) @(negedge MasterClock);
    n_checks++;
    if ({an, seg, dp, Busy} !== {4'b1111, 7'b1111111, 1'b1, 1'b0})
      $display("FAIL reset_outputs: an/seg/dp/Busy got %b/%b/%b/%b expected 1111/1111111/1/0", an, seg, dp, Busy);
    else n_pass++;
    Reset = 1'b0;
    tb_digit = 0;
    shown = 0;
    @(negedge MasterClock);
    n_checks++;
    if (Busy !== 1'b1) $display("FAIL reset_busy_start: Busy got %b expected 1", Busy);
    else n_pass++;
    busy_cycles = 1;
    for (int i = 0; i < 30; i++) begin
      @(negedge MasterClock);
      if (Busy === 1'b1) busy_cycles++;
    end
    n_checks++;
    if (busy_cycles != 15) $display("FAIL reset_busy_len: Busy cycles got %0d expected 15", busy_cycles);
    else n_pass++;
    n_checks++;
    if ({an, seg} !== exp_out(0, 0, 1'b0))
      $display("FAIL reset_zero_digit: an/seg got %b/%b expected 1110/1000000", an, seg);
    else n_pass++;
  endtask

  task automatic test_full_scan();
    load(1234);
    for (int i = 0; i < 4; i++) begin
      tick();
      @(negedge MasterClock);
      e = exp_q.pop_front();
      n_checks++;
      if ({an, seg} !== e) $display("FAIL full_scan[%0d]: an/seg got %b/%b expected %b/%b", i, an, seg, e[10:7], e[6:0]);
      else n_pass++;
      settle();
    end
  endtask

  task automatic test_leading_zero();
    load(7);
    for (int i = 0; i < 4; i++) begin
      tick();
      @(negedge MasterClock);
      e = exp_q.pop_front();
      n_checks++;
      if ({an, seg} !== e) $display("FAIL lead_zero_7[%0d]: an/seg got %b/%b expected %b/%b", i, an, seg, e[10:7], e[6:0]);
      else n_pass++;
      settle();
    end
    load(0);
    for (int i = 0; i < 4; i++) begin
      tick();
      @(negedge MasterClock);
      e = exp_q.pop_front();
      n_checks++;
      if ({an, seg} !== e) $display("FAIL lead_zero_0[%0d]: an/seg got %b/%b expected %b/%b", i, an, seg, e[10:7], e[6:0]);
      else n_pass++;
      settle();
    end
  endtask

  task automatic test_clamp();
    load(12000);
    for (int i = 0; i < 4; i++) begin
      tick();
      @(negedge MasterClock);
      e = exp_q.pop_front();
      n_checks++;
      if ({an, seg} !== e) $display("FAIL clamp[%0d]: an/seg got %b/%b expected %b/%b", i, an, seg, e[10:7], e[6:0]);
      else n_pass++;
      settle();
    end
  endtask

  task automatic test_capture_timing();
    load(1234);
    for (int i = 0; i < 8; i++) begin
      tick();
      if (i == 0) Value = 14'd5678;
      @(negedge MasterClock);
      e = exp_q.pop_front();
      n_checks++;
      if ({an, seg} !== e) $display("FAIL capture_timing[%0d]: an/seg got %b/%b expected %b/%b", i, an, seg, e[10:7], e[6:0]);
      else n_pass++;
      settle();
    end
  endtask

  task automatic test_blank();
    @(negedge MasterClock);
    Blank = 1'b1;
    @(negedge MasterClock);
    n_checks++;
    if ({an, seg} !== {4'b1111, 7'b1111111}) $display("FAIL blank_now: an/seg got %b/%b expected 1111/1111111", an, seg);
    else n_pass++;
    for (int i = 0; i < 2; i++) begin
      tick();
      @(negedge MasterClock);
      e = exp_q.pop_front();
      n_checks++;
      if ({an, seg} !== e) $display("FAIL blank_tick[%0d]: an/seg got %b/%b expected %b/%b", i, an, seg, e[10:7], e[6:0]);
      else n_pass++;
      settle();
    end
    Blank = 1'b0;
    exp_q.push_back(exp_out(shown, tb_digit, 1'b0));
    repeat (2) @(negedge MasterClock);
    e = exp_q.pop_front();
    n_checks++;
    if ({an, seg} !== e) $display("FAIL blank_release: an/seg got %b/%b expected %b/%b", an, seg, e[10:7], e[6:0]);
    else n_pass++;
  endtask

  task automatic test_reset_mid_conversion();
    Value = 14'd4321;
    while (tb_digit != 3) begin
      tick();
      @(negedge MasterClock);
      void'(exp_q.pop_front());
      settle();
    end
    tick();
    void'(exp_q.pop_front());
    pending_valid = 1'b0;
    repeat (4) @(negedge MasterClock);
    n_checks++;
    if (Busy !== 1'b1) $display("FAIL midconv_busy: Busy got %b expected 1", Busy);
    else n_pass++;
    Reset = 1'b1;
    repeat (2) @(negedge MasterClock);
    n_checks++;
    if ({an, seg, dp, Busy} !== {4'b1111, 7'b1111111, 1'b1, 1'b0})
      $display("FAIL midconv_reset: an/seg/dp/Busy got %b/%b/%b/%b expected 1111/1111111/1/0", an, seg, dp, Busy);
    else n_pass++;
    Reset = 1'b0;
    tb_digit = 0;
    shown = 0;
    @(negedge MasterClock);
    n_checks++;
    if ({Busy, an, seg} !== {1'b1, exp_out(0, 0, 1'b0)})
      $display("FAIL midconv_restart: Busy/an/seg got %b/%b/%b expected 1/1110/1000000", Busy, an, seg);
    else n_pass++;
    repeat (20) @(negedge MasterClock);
    shown = 4321;
    for (int i = 0; i < 4; i++) begin
      tick();
      @(negedge MasterClock);
      e = exp_q.pop_front();
      n_checks++;
      if ({an, seg} !== e) $display("FAIL midconv_scan[%0d]: an/seg got %b/%b expected %b/%b", i, an, seg, e[10:7], e[6:0]);
      else n_pass++;
      settle();
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_full_scan();
    test_leading_zero();
    test_clamp();
    test_capture_timing();
    test_blank();
    test_reset_mid_conversion();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
